// File: rtl/alt_mon_pkg.sv
// rtl/alt_mon_pkg.sv - shared types, default widths and saturating helper for the event monitor
//
// Purpose : common definitions imported by alt_event_monitor and alt_mon_result_reg.
// Contents: CNT_W_DEF / WIN_W_DEF default widths, mon_state_e (IDLE, COUNT),
//           sat_inc() saturating increment on a 32-bit carrier.
package alt_mon_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } mon_state_e;

  // Returns value+1 when inc is set, unless value already sits at max_value.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value,
                                          input logic        inc);
    logic [31:0] res;
    res = value;
    if (inc && (value != max_value)) res = value + 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/alt_mon_result_reg.sv
// rtl/alt_mon_result_reg.sv - single-entry window result register with valid/ready and overrun
//
// Purpose : holds the final count of the last completed window until the reader takes it.
// Ports   : clk, rst (async, active-low), clr (sync clear)
//           load / load_count : a window just ended with this count
//           ready             : reader accepts when valid & ready
//           valid, count      : unread result
//           overrun           : sticky, a load replaced an unread result
import alt_mon_pkg::*;

module alt_mon_result_reg #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_count,
  input  logic             ready,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overrun
);

  logic accept;
  assign accept = valid & ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (clr) begin
      valid   <= 1'b0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (load) begin
      // A load coincident with an accept is a clean hand-over, not an overrun.
      count <= load_count;
      valid <= 1'b1;
      if (valid && !accept) overrun <= 1'b1;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alt_event_monitor.sv
// rtl/alt_event_monitor.sv - windowed event counter with threshold alarm for detector z pulses
//
// Purpose : counts z_in pulses over back-to-back windows of win_len clocks, raises a
//           one-shot alarm per window at thresh, and hands each window count to a reader.
// Ports   : clk, rst (async, active-low), en (low aborts window), clr (sync clear)
//           z_in, win_len (0 acts as 1), thresh (0 disables alarm)
//           live_count, alarm, result_valid/result_ready/result_count, overrun
import alt_mon_pkg::*;

module alt_event_monitor #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             z_in,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] live_count,
  output logic             alarm,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_count,
  output logic             overrun
);

  localparam logic [0:0]  ST_IDLE  = IDLE;
  localparam logic [0:0]  ST_COUNT = COUNT;
  localparam logic [31:0] CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

  logic [0:0]       state;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] last_cnt;
  logic [CNT_W-1:0] count_next;
  logic             armed;
  logic             win_end;
  logic             hit;

  // A latched length of 0 behaves as a one-clock window.
  assign last_cnt   = (len_q == '0) ? '0 : len_q - WIN_W'(1);
  // Count including the pulse sampled at this edge.
  assign count_next = CNT_W'(sat_inc(32'(live_count), CNT_MAX, z_in));
  assign win_end    = (state == ST_COUNT) && en && !clr && (win_cnt == last_cnt);
  assign hit        = armed && (thresh != '0) && (count_next >= thresh);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      win_cnt    <= '0;
      live_count <= '0;
      armed      <= 1'b0;
      alarm      <= 1'b0;
    end else if (clr) begin
      state      <= ST_IDLE;
      win_cnt    <= '0;
      live_count <= '0;
      armed      <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      alarm <= 1'b0;
      if (state == ST_IDLE) begin
        win_cnt    <= '0;
        live_count <= '0;
        if (en) begin
          state <= ST_COUNT;
          len_q <= win_len;
          armed <= 1'b1;
        end
      end else if (!en) begin
        // Abort: partial count is dropped, result register is left alone.
        state      <= ST_IDLE;
        win_cnt    <= '0;
        live_count <= '0;
        armed      <= 1'b0;
      end else begin
        if (hit) begin
          alarm <= 1'b1;
          armed <= 1'b0;
        end
        if (win_end) begin
          // Next window starts on the following clock with a fresh length and re-armed alarm.
          win_cnt    <= '0;
          live_count <= '0;
          len_q      <= win_len;
          armed      <= 1'b1;
        end else begin
          win_cnt    <= win_cnt + WIN_W'(1);
          live_count <= count_next;
        end
      end
    end
  end

  alt_mon_result_reg #(
    .CNT_W (CNT_W)
  ) u_result (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load       (win_end),
    .load_count (count_next),
    .ready      (result_ready),
    .valid      (result_valid),
    .count      (result_count),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_alt_event_monitor.sv
// tb/tb_alt_event_monitor.sv - self-checking bench for alt_event_monitor with reference model
module tb_alt_event_monitor;

  localparam int CW   = 4;
  localparam int WW   = 16;
  localparam int MAXC = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clr;
  logic          z_in;
  logic [WW-1:0] win_len;
  logic [CW-1:0] thresh;
  logic [CW-1:0] live_count;
  logic          alarm;
  logic          result_valid;
  logic          result_ready;
  logic [CW-1:0] result_count;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int n_alarm  = 0;

  // Reference model state: window position, unsaturated event tally, result slot.
  bit m_active, m_armed, m_alarm, m_rv, m_ovr;
  int m_pos, m_len, m_events, m_res;

  always #5 clk = ~clk;

  alt_event_monitor #(.CNT_W(CW), .WIN_W(WW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .z_in         (z_in),
    .win_len      (win_len),
    .thresh       (thresh),
    .live_count   (live_count),
    .alarm        (alarm),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_count (result_count),
    .overrun      (overrun)
  );

  function automatic int eff_len(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_armed = 0; m_alarm = 0; m_rv = 0; m_ovr = 0;
    m_pos = 0; m_len = 1; m_events = 0; m_res = 0;
  endtask

  // Applies one rising edge's worth of the monitor rules to the model.
  task automatic model_step();
    bit acc;
    int cnt;
    if (!rst) begin
      model_reset();
    end else begin
      acc     = m_rv && result_ready;
      m_alarm = 0;
      if (clr) begin
        m_active = 0; m_armed = 0; m_rv = 0; m_ovr = 0;
        m_pos = 0; m_events = 0; m_res = 0;
      end else if (m_active && en) begin
        cnt = sat(m_events + int'(z_in));
        if (m_armed && thresh != 0 && cnt >= int'(thresh)) begin
          m_alarm = 1;
          m_armed = 0;
        end
        if (m_pos == m_len - 1) begin
          if (m_rv && !acc) m_ovr = 1;
          m_res = cnt; m_rv = 1;
          m_pos = 0; m_events = 0;
          m_len = eff_len(int'(win_len));
          m_armed = 1;
        end else begin
          m_pos++;
          m_events += int'(z_in);
          if (acc) m_rv = 0;
        end
      end else begin
        if (acc) m_rv = 0;
        if (m_active) begin
          m_active = 0; m_pos = 0; m_events = 0; m_armed = 0;
        end else if (en) begin
          m_active = 1; m_pos = 0; m_events = 0; m_armed = 1;
          m_len = eff_len(int'(win_len));
        end
      end
    end
  endtask

  task automatic compare_all();
    if (alarm === 1'b1) n_alarm++;
    check("live_count",   32'(live_count),   32'(sat(m_events)));
    check("alarm",        32'(alarm),        32'(m_alarm));
    check("result_valid", 32'(result_valid), 32'(m_rv));
    check("result_count", 32'(result_count), 32'(m_res));
    check("overrun",      32'(overrun),      32'(m_ovr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    rst = 1'b0; en = 1'b0; clr = 1'b0; z_in = 1'b0;
    win_len = '0; thresh = '0; result_ready = 1'b0;
    model_reset();
    tick();
    tick();
    check("reset_live",  32'(live_count),   32'd0);
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_ovr",   32'(overrun),      32'd0);
    rst = 1'b1;

    // Basic count: 8-clock window, pulses on cycles 1, 3, 6.
    win_len = 16'd8; thresh = 4'd0; en = 1'b1;
    tick();
    n_alarm = 0;
    for (int c = 0; c < 8; c++) begin
      z_in = (c == 1 || c == 3 || c == 6);
      tick();
    end
    z_in = 1'b0;
    check("basic_valid", 32'(result_valid), 32'd1);
    check("basic_count", 32'(result_count), 32'd3);
    check("basic_noalarm", 32'(n_alarm), 32'd0);

    // Alarm: threshold 2 reached on window cycle 4.
    en = 1'b0; tick();
    result_ready = 1'b1; tick();
    result_ready = 1'b0;
    win_len = 16'd10; thresh = 4'd2; en = 1'b1;
    tick();
    n_alarm = 0;
    for (int c = 0; c < 10; c++) begin
      z_in = (c == 2 || c == 4 || c == 5);
      tick();
      if (c == 4) check("alarm_pulse", 32'(alarm), 32'd1);
      if (c == 5) check("alarm_norepeat", 32'(alarm), 32'd0);
    end
    z_in = 1'b0;
    check("alarm_once", 32'(n_alarm), 32'd1);
    check("alarm_count", 32'(result_count), 32'd3);

    // Overrun, then accept exactly on a window end.
    en = 1'b0; tick();
    clr = 1'b1; tick();
    clr = 1'b0;
    win_len = 16'd4; thresh = 4'd0; z_in = 1'b1; en = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) tick();
    check("ovr_count", 32'(result_count), 32'd4);
    check("ovr_flag",  32'(overrun),      32'd1);
    for (int c = 0; c < 4; c++) begin
      result_ready = (c == 3);
      tick();
    end
    result_ready = 1'b0;
    check("coinc_valid", 32'(result_valid), 32'd1);
    check("coinc_count", 32'(result_count), 32'd4);
    check("coinc_ovr",   32'(overrun),      32'd1);

    // Saturation at 15 with a 20-clock window.
    en = 1'b0; tick();
    result_ready = 1'b1; tick();
    result_ready = 1'b0;
    win_len = 16'd20; en = 1'b1; z_in = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 18) check("sat_live", 32'(live_count), 32'd15);
    end
    check("sat_result", 32'(result_count), 32'd15);

    // Abort at window cycle 3 of 8, then clear.
    en = 1'b0; tick();
    win_len = 16'd8; en = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) tick();
    en = 1'b0; z_in = 1'b0;
    tick();
    check("abort_live",  32'(live_count),   32'd0);
    check("abort_valid", 32'(result_valid), 32'd1);
    check("abort_count", 32'(result_count), 32'd15);
    clr = 1'b1; tick();
    clr = 1'b0;
    check("clr_valid", 32'(result_valid), 32'd0);
    check("clr_ovr",   32'(overrun),      32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      en           = ($urandom_range(0, 15) != 0);
      clr          = ($urandom_range(0, 40) == 0);
      z_in         = 1'($urandom_range(0, 1));
      win_len      = 16'($urandom_range(0, 6));
      thresh       = 4'($urandom_range(0, 5));
      result_ready = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Asynchronous reset mid-window, then time the first window after release.
    clr = 1'b0; result_ready = 1'b0; z_in = 1'b0; thresh = '0;
    win_len = 16'd5; en = 1'b1;
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("arst_alarm", 32'(alarm),        32'd0);
    check("arst_count", 32'(result_count), 32'd0);
    #2 rst = 1'b1;
    // One entry edge from IDLE, then win_len window clocks.
    n = 0;
    while (n < 50) begin
      tick();
      n++;
      if (result_valid === 1'b1) break;
    end
    check("first_window_edges", 32'(n), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alt_event_monitor.md
Name: alt_event_monitor

Overview:
- Downstream consumer of the alternating-0s/1s detector's z output.
- Counts detector pulses over programmable, back-to-back observation windows of N clocks.
- Raises a per-window threshold alarm.
- Delivers each window's final count through a single-entry valid/ready result port to the bus-side reader.

Parameters:
- CNT_W, 8, width of event counter and result (saturating)
- WIN_W, 16, width of window-length counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  monitor enable; low aborts the current window
- clr  in  1  synchronous clear of counters, result and flags
- z_in  in  1  detector pulse; sampled every rising clk edge
- win_len  in  WIN_W  window length in clocks; sampled at window start; 0 is treated as 1
- thresh  in  CNT_W  alarm threshold; 0 disables the alarm
- live_count  out  CNT_W  running count in the current window
- alarm  out  1  one-cycle pulse, at most once per window
- result_valid  out  1  result holds an unread window count
- result_ready  in  1  reader accepts the result when result_valid & result_ready
- result_count  out  CNT_W  final count of the last completed window
- overrun  out  1  sticky; a completed window overwrote an unread result

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0, and win_cnt, live_count, result_count and overrun are all 0.
- FSM states are IDLE and COUNT.
- IDLE:
  - live_count and win_cnt are held at 0.
  - en=1 and clr=0 -> COUNT next cycle; win_len is latched into len_q at that edge.
- COUNT, every cycle:
  - win_cnt increments.
  - If z_in=1, live_count increments, saturating at 2^CNT_W-1.
  - Window end is the cycle with win_cnt==len_q-1. At that edge:
    - result_count <= live_count + z_in (saturated).
    - result_valid <= 1.
    - live_count <= 0, win_cnt <= 0.
    - len_q <= current win_len.
    - State stays COUNT, so windows run back-to-back with no gap cycle.
- en=0 in COUNT aborts the window: the partial count is discarded, state goes to IDLE next cycle, and result_* is untouched.
- Alarm:
  - Pulses 1 cycle on the edge where the count (including the current z_in) first becomes >= thresh, only when thresh != 0.
  - A per-window armed flag blocks repeats; the flag re-arms at window start.
- Result handshake:
  - Accept is result_valid & result_ready; on accept, result_valid <= 0 next cycle.
  - Window end with result_valid=1 and no accept in the same cycle: overwrite result_count and set overrun=1.
  - Window end coincident with an accept: load the new count, result_valid stays 1, overrun is unchanged.
  - overrun clears only on clr or reset.
  - result_count is stable while result_valid=1 unless an overrun overwrites it.
- clr=1 (priority over everything except rst):
  - Next cycle live_count, win_cnt, result_valid, result_count, overrun and the armed flag are 0, and state=IDLE.
  - If en stays high, the block re-enters COUNT on the cycle after clr deasserts.
- z_in is used only in COUNT. It is combinational from the upstream Mealy FSM, so it is sampled strictly at clk edges; no filtering is required.
- Latency: result_valid rises 1 clk after the window-end cycle. alarm is registered and appears 1 clk after the qualifying z_in edge sample.

Decomposition:
- Package alt_mon_pkg holds:
  - the state enum (IDLE, COUNT);
  - the default CNT_W/WIN_W constants;
  - the saturating-increment function.
- One natural sub-module: alt_mon_result_reg, the single-entry result register with the valid/ready handshake and overrun logic.
- Window/count FSM stays in the top level.

Test Plan:
- Basic count:
  - Stimulus: win_len=8, thresh=0, en=1; z_in=1 on window cycles 1, 3 and 6.
  - Required: result_valid rises 1 clk after cycle 7 with result_count=3; alarm never asserts.
- Alarm:
  - Stimulus: win_len=10, thresh=2, z_in=1 on window cycles 2, 4 and 5.
  - Required: a single alarm pulse, the cycle after window cycle 4; no pulse after cycle 5; result_count=3.
- Overrun and coincident accept:
  - Stimulus: win_len=4, z_in constantly 1, result_ready=0 for two windows.
  - Required: result_count=4, overrun=1 after the second window end.
  - Then assert result_ready exactly on a window-end cycle: required result_valid stays 1, the new count is 4, and overrun stays 1 until clr.
- Saturation:
  - Stimulus: CNT_W=4, win_len=20, z_in constantly 1.
  - Required: live_count sticks at 15; result_count=15.
- Abort and clear:
  - Stimulus: drop en at window cycle 3 of 8.
  - Required: IDLE, live_count=0, prior result retained.
  - Then pulse clr: required result_valid=0, overrun=0.
- Reset mid-window:
  - Stimulus: assert rst low asynchronously between edges.
  - Required: all outputs 0 immediately. After release with en=1, the first window completes after exactly win_len clocks.
